dual_result_bcast: RTL and testbench

- Producer side of the dual-issue operand-forwarding interface.
- Takes per-lane EX-stage results (lane 1 older, lane 2 younger) and pipelines them through the MEM and WB registers.
- Publishes the ex_*/mem_* broadcast buses that the forwarding units consume, drives both register-file write ports, and raises a load-use stall request when a consumer needs a load result not yet available.

---
 rtl/dual_result_bcast.sv | 157 +++++++++++++++
 tb/tb_dual_result_bcast.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dual_result_bcast.sv
// Dual-lane result broadcast: EX/MEM/WB result pipeline feeding forwarding units and regfile writes.
// Latency: EX bus combinational, MEM +1 cycle, WB +2 cycles; load_use_stall_req combinational.
// Backpressure: stall[2]/stall[3] bubble or hold MEM/WB, flush squashes; REG0_SQUASH_EN drops $0 writes.
module dual_result_bcast #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic [3:0]        stall,
   input  logic              ex_we_i1,
   input  logic              ex_we_i2,
   input  logic [ADDR_W-1:0] ex_waddr_i1,
   input  logic [ADDR_W-1:0] ex_waddr_i2,
   input  logic [DATA_W-1:0] ex_wdata_i1,
   input  logic [DATA_W-1:0] ex_wdata_i2,
   input  logic              ex_load_i1,
   input  logic              ex_load_i2,
   input  logic [DATA_W-1:0] mem_ldata_i1,
   input  logic [DATA_W-1:0] mem_ldata_i2,
   input  logic              re1,
   input  logic              re2,
   input  logic [ADDR_W-1:0] raddr1,
   input  logic [ADDR_W-1:0] raddr2,
   output logic              ex_we_o1,
   output logic              ex_we_o2,
   output logic [ADDR_W-1:0] ex_waddr_o1,
   output logic [ADDR_W-1:0] ex_waddr_o2,
   output logic [DATA_W-1:0] ex_wdata_o1,
   output logic [DATA_W-1:0] ex_wdata_o2,
   output logic              mem_we_o1,
   output logic              mem_we_o2,
   output logic [ADDR_W-1:0] mem_waddr_o1,
   output logic [ADDR_W-1:0] mem_waddr_o2,
   output logic [DATA_W-1:0] mem_wdata_o1,
   output logic [DATA_W-1:0] mem_wdata_o2,
   output logic              wb_we_o1,
   output logic              wb_we_o2,
   output logic [ADDR_W-1:0] wb_waddr_o1,
   output logic [ADDR_W-1:0] wb_waddr_o2,
   output logic [DATA_W-1:0] wb_wdata_o1,
   output logic [DATA_W-1:0] wb_wdata_o2,
   output logic              load_use_stall_req
);

`ifdef REG0_SQUASH_EN
   localparam bit SQUASH_R0 = 1'b1;
`else
   localparam bit SQUASH_R0 = 1'b0;
`endif

   typedef struct packed {
      logic              we;
      logic              load;
      logic [ADDR_W-1:0] waddr;
      logic [DATA_W-1:0] wdata;
   } lane_t;

   function automatic logic live(input logic we, input logic [ADDR_W-1:0] addr);
      return we && !(SQUASH_R0 && addr == '0);
   endfunction

   lane_t             ex_l  [2];
   lane_t             mem_q [2];
   lane_t             mem_v [2];
   lane_t             wb_q  [2];
   logic [DATA_W-1:0] ldata [2];
   logic              re    [2];
   logic [ADDR_W-1:0] raddr [2];
   logic              wb_live1;
   logic              wb_live2;
   logic              lu_hit;
   logic              unused_bits;

   always_comb begin
      ex_l[0]  = '{we: live(ex_we_i1 & ~flush, ex_waddr_i1), load: ex_load_i1,
                   waddr: ex_waddr_i1, wdata: ex_wdata_i1};
      ex_l[1]  = '{we: live(ex_we_i2 & ~flush, ex_waddr_i2), load: ex_load_i2,
                   waddr: ex_waddr_i2, wdata: ex_wdata_i2};
      ldata[0] = mem_ldata_i1;
      ldata[1] = mem_ldata_i2;
      re[0]    = re1;
      re[1]    = re2;
      raddr[0] = raddr1;
      raddr[1] = raddr2;
   end

   // Load data is merged here, so WB never needs to know a lane was a load.
   always_comb begin
      for (int n = 0; n < 2; n++) begin
         mem_v[n]       = mem_q[n];
         mem_v[n].we    = live(mem_q[n].we, mem_q[n].waddr);
         mem_v[n].load  = 1'b0;
         mem_v[n].wdata = mem_q[n].load ? ldata[n] : mem_q[n].wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int n = 0; n < 2; n++) begin
            mem_q[n] <= '0;
            wb_q[n]  <= '0;
         end
      end else begin
         for (int n = 0; n < 2; n++) begin
            if (flush)                     mem_q[n].we <= 1'b0;
            else if (stall[2] && !stall[3]) mem_q[n].we <= 1'b0;
            else if (!stall[2])            mem_q[n]    <= ex_l[n];

            if (flush)          wb_q[n].we <= 1'b0;
            else if (!stall[3]) wb_q[n]    <= mem_v[n];
         end
      end
   end

   // Both lanes hitting one register in WB: the younger lane 2 owns the write.
   always_comb begin
      wb_live2 = live(wb_q[1].we, wb_q[1].waddr);
      wb_live1 = live(wb_q[0].we, wb_q[0].waddr) &&
                 !(wb_live2 && wb_q[0].waddr == wb_q[1].waddr);
   end

   always_comb begin
      lu_hit = 1'b0;
      for (int p = 0; p < 2; p++)
         for (int n = 0; n < 2; n++)
            if (re[p] && ex_l[n].we && ex_l[n].load && ex_l[n].waddr == raddr[p])
               lu_hit = 1'b1;
   end

   assign load_use_stall_req = lu_hit && !flush;

   assign ex_we_o1     = ex_l[0].we;
   assign ex_we_o2     = ex_l[1].we;
   assign ex_waddr_o1  = ex_waddr_i1;
   assign ex_waddr_o2  = ex_waddr_i2;
   assign ex_wdata_o1  = ex_wdata_i1;
   assign ex_wdata_o2  = ex_wdata_i2;

   assign mem_we_o1    = mem_v[0].we;
   assign mem_we_o2    = mem_v[1].we;
   assign mem_waddr_o1 = mem_v[0].waddr;
   assign mem_waddr_o2 = mem_v[1].waddr;
   assign mem_wdata_o1 = mem_v[0].wdata;
   assign mem_wdata_o2 = mem_v[1].wdata;

   assign wb_we_o1     = wb_live1;
   assign wb_we_o2     = wb_live2;
   assign wb_waddr_o1  = wb_q[0].waddr;
   assign wb_waddr_o2  = wb_q[1].waddr;
   assign wb_wdata_o1  = wb_q[0].wdata;
   assign wb_wdata_o2  = wb_q[1].wdata;

   assign unused_bits  = ^{stall[1:0], wb_q[0].load, wb_q[1].load};

endmodule

// File: tb/tb_dual_result_bcast.sv
// Bench for dual_result_bcast: directed vector table, hand-written stage sequences, randomized run vs. a stage model.
module tb_dual_result_bcast;

   logic        clk = 1'b0;
   logic        rst, flush;
   logic [3:0]  stall;
   logic        ex_we_i1, ex_we_i2, ex_load_i1, ex_load_i2, re1, re2;
   logic [4:0]  ex_waddr_i1, ex_waddr_i2, raddr1, raddr2;
   logic [31:0] ex_wdata_i1, ex_wdata_i2, mem_ldata_i1, mem_ldata_i2;
   logic        ex_we_o1, ex_we_o2, mem_we_o1, mem_we_o2, wb_we_o1, wb_we_o2;
   logic [4:0]  ex_waddr_o1, ex_waddr_o2, mem_waddr_o1, mem_waddr_o2, wb_waddr_o1, wb_waddr_o2;
   logic [31:0] ex_wdata_o1, ex_wdata_o2, mem_wdata_o1, mem_wdata_o2, wb_wdata_o1, wb_wdata_o2;
   logic        load_use_stall_req;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   dual_result_bcast #(.DATA_W(32), .ADDR_W(5)) dut (
      .clk(clk), .rst(rst), .flush(flush), .stall(stall),
      .ex_we_i1(ex_we_i1), .ex_we_i2(ex_we_i2),
      .ex_waddr_i1(ex_waddr_i1), .ex_waddr_i2(ex_waddr_i2),
      .ex_wdata_i1(ex_wdata_i1), .ex_wdata_i2(ex_wdata_i2),
      .ex_load_i1(ex_load_i1), .ex_load_i2(ex_load_i2),
      .mem_ldata_i1(mem_ldata_i1), .mem_ldata_i2(mem_ldata_i2),
      .re1(re1), .re2(re2), .raddr1(raddr1), .raddr2(raddr2),
      .ex_we_o1(ex_we_o1), .ex_we_o2(ex_we_o2),
      .ex_waddr_o1(ex_waddr_o1), .ex_waddr_o2(ex_waddr_o2),
      .ex_wdata_o1(ex_wdata_o1), .ex_wdata_o2(ex_wdata_o2),
      .mem_we_o1(mem_we_o1), .mem_we_o2(mem_we_o2),
      .mem_waddr_o1(mem_waddr_o1), .mem_waddr_o2(mem_waddr_o2),
      .mem_wdata_o1(mem_wdata_o1), .mem_wdata_o2(mem_wdata_o2),
      .wb_we_o1(wb_we_o1), .wb_we_o2(wb_we_o2),
      .wb_waddr_o1(wb_waddr_o1), .wb_waddr_o2(wb_waddr_o2),
      .wb_wdata_o1(wb_wdata_o1), .wb_wdata_o2(wb_wdata_o2),
      .load_use_stall_req(load_use_stall_req)
   );

`ifdef REG0_SQUASH_EN
   localparam bit R0_SQ = 1'b1;
`else
   localparam bit R0_SQ = 1'b0;
`endif

   // One result slot as the pipeline sees it: what register, what value, does it write.
   typedef struct {
      bit        we;
      bit        load;
      bit [4:0]  waddr;
      bit [31:0] wdata;
   } rec_t;

   rec_t m_mem [2];
   rec_t m_wb  [2];
   rec_t e_mem [2];
   rec_t e_wb  [2];

   typedef struct {
      bit       flush;
      bit       we1, ld1; bit [4:0] a1;
      bit       we2, ld2; bit [4:0] a2;
      bit       re1;      bit [4:0] r1;
      bit       re2;      bit [4:0] r2;
      bit       exp_lu, exp_we1, exp_we2;
   } vec_t;

   function automatic bit writes(bit we, bit [4:0] a);
      return we && !(R0_SQ && a == 5'd0);
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h want %h", name, act, exp);
      end
   endtask

   task automatic chk_lane(input string name, input logic we, input logic [4:0] a,
                           input logic [31:0] d, input rec_t e);
      if (e.we) chk(name, {we, a, d}, {1'b1, e.waddr, e.wdata});
      else      chk(name, {63'd0, we}, 64'd0);
   endtask

   task automatic idle();
      ex_we_i1 = 0; ex_we_i2 = 0; ex_load_i1 = 0; ex_load_i2 = 0;
      ex_waddr_i1 = 0; ex_waddr_i2 = 0; ex_wdata_i1 = 0; ex_wdata_i2 = 0;
      re1 = 0; re2 = 0; raddr1 = 0; raddr2 = 0;
   endtask

   task automatic lane1(input bit we, input bit [4:0] a, input bit [31:0] d, input bit ld);
      ex_we_i1 = we; ex_waddr_i1 = a; ex_wdata_i1 = d; ex_load_i1 = ld;
   endtask

   task automatic lane2(input bit we, input bit [4:0] a, input bit [31:0] d, input bit ld);
      ex_we_i2 = we; ex_waddr_i2 = a; ex_wdata_i2 = d; ex_load_i2 = ld;
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Expected visible stage outputs, derived from what each stage currently holds.
   task automatic model_outputs();
      logic [31:0] ld [2];
      ld[0] = mem_ldata_i1;
      ld[1] = mem_ldata_i2;
      for (int n = 0; n < 2; n++) begin
         e_mem[n].we    = writes(m_mem[n].we, m_mem[n].waddr);
         e_mem[n].load  = 1'b0;
         e_mem[n].waddr = m_mem[n].waddr;
         e_mem[n].wdata = m_mem[n].load ? ld[n] : m_mem[n].wdata;
         e_wb[n]        = m_wb[n];
         e_wb[n].we     = writes(m_wb[n].we, m_wb[n].waddr);
      end
      if (e_wb[0].we && e_wb[1].we && m_wb[0].waddr == m_wb[1].waddr) e_wb[0].we = 1'b0;
   endtask

   task automatic model_clock();
      rec_t ex [2];
      model_outputs();
      ex[0] = '{writes(ex_we_i1, ex_waddr_i1), ex_load_i1, ex_waddr_i1, ex_wdata_i1};
      ex[1] = '{writes(ex_we_i2, ex_waddr_i2), ex_load_i2, ex_waddr_i2, ex_wdata_i2};
      for (int n = 0; n < 2; n++) begin
         if (!rst) begin
            m_mem[n] = '{0, 0, 0, 0};
            m_wb[n]  = '{0, 0, 0, 0};
         end else begin
            if (flush)          m_wb[n].we = 1'b0;
            else if (!stall[3]) m_wb[n]    = e_mem[n];
            if (flush)                     m_mem[n].we = 1'b0;
            else if (stall[2] && !stall[3]) m_mem[n].we = 1'b0;
            else if (!stall[2])            m_mem[n]    = ex[n];
         end
      end
   endtask

   function automatic bit exp_lu();
      bit       r [2];
      bit [4:0] ra [2];
      bit       w [2];
      bit       l [2];
      bit [4:0] wa [2];
      bit       hit = 0;
      r = '{re1, re2}; ra = '{raddr1, raddr2};
      w = '{writes(ex_we_i1, ex_waddr_i1), writes(ex_we_i2, ex_waddr_i2)};
      l = '{ex_load_i1, ex_load_i2}; wa = '{ex_waddr_i1, ex_waddr_i2};
      for (int p = 0; p < 2; p++)
         for (int n = 0; n < 2; n++)
            if (r[p] && w[n] && l[n] && wa[n] == ra[p]) hit = 1;
      return hit && !flush;
   endfunction

   vec_t vt [9];

   initial begin
      rst = 0; flush = 0; stall = 0; mem_ldata_i1 = 0; mem_ldata_i2 = 0;
      idle();

      vt[0] = '{0, 1,1,5,  0,0,0,  1,5,  0,0,  1,1,0};
      vt[1] = '{1, 1,1,5,  0,0,0,  1,5,  0,0,  0,0,0};
      vt[2] = '{0, 1,0,5,  0,0,0,  1,5,  0,0,  0,1,0};
      vt[3] = '{0, 0,0,0,  1,1,7,  0,0,  1,7,  1,0,1};
      vt[4] = '{0, 0,0,0,  1,1,7,  1,7,  0,0,  1,0,1};
      vt[5] = '{0, 0,0,0,  1,1,7,  0,7,  0,7,  0,0,1};
      vt[6] = '{0, 0,1,3,  0,0,0,  1,3,  0,0,  0,0,0};
      vt[7] = '{0, 1,1,3,  0,0,0,  1,4,  0,0,  0,1,0};
      vt[8] = '{0, 1,0,2,  1,1,9,  0,0,  1,9,  1,1,1};

      // Reset with live EX inputs: MEM/WB stay empty.
      lane1(1, 3, 32'h11, 0); lane2(1, 4, 32'h22, 0);
      tick(); tick();
      #1;
      chk("rst_mem1", {mem_we_o1, mem_waddr_o1, mem_wdata_o1}, 64'd0);
      chk("rst_mem2", {mem_we_o2, mem_waddr_o2, mem_wdata_o2}, 64'd0);
      chk("rst_wb1",  {wb_we_o1, wb_waddr_o1, wb_wdata_o1}, 64'd0);
      chk("rst_wb2",  {wb_we_o2, wb_waddr_o2, wb_wdata_o2}, 64'd0);
      rst = 1; lane2(0, 0, 0, 0);
      tick(); idle(); #1;
      chk("lat_mem1", {mem_we_o1, mem_waddr_o1, mem_wdata_o1}, {1'b1, 5'd3, 32'h11});
      tick(); #1;
      chk("lat_wb1",  {wb_we_o1, wb_waddr_o1, wb_wdata_o1}, {1'b1, 5'd3, 32'h11});
      chk("lat_wb2",  {63'd0, wb_we_o2}, 64'd0);

      // Combinational EX broadcast and load-use table.
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         flush = vt[i].flush;
         lane1(vt[i].we1, vt[i].a1, 32'h100 + i, vt[i].ld1);
         lane2(vt[i].we2, vt[i].a2, 32'h200 + i, vt[i].ld2);
         re1 = vt[i].re1; raddr1 = vt[i].r1; re2 = vt[i].re2; raddr2 = vt[i].r2;
         #1;
         chk($sformatf("vec%0d_lu", i), {63'd0, load_use_stall_req}, {63'd0, vt[i].exp_lu});
         chk($sformatf("vec%0d_we", i), {62'd0, ex_we_o1, ex_we_o2}, {62'd0, vt[i].exp_we1, vt[i].exp_we2});
      end
      @(negedge clk); flush = 0; idle(); tick();

      // Same destination on both lanes.
      lane1(1, 8, 32'hAAAA, 0); lane2(1, 8, 32'hBBBB, 0);
      tick(); idle(); #1;
      chk("sd_mem", {mem_we_o1, mem_we_o2, mem_waddr_o1, mem_waddr_o2, mem_wdata_o1[15:0], mem_wdata_o2[15:0]},
          {2'b11, 5'd8, 5'd8, 16'hAAAA, 16'hBBBB});
      tick(); #1;
      chk("sd_wb", {wb_we_o1, wb_we_o2, wb_waddr_o2, wb_wdata_o2}, {1'b0, 1'b1, 5'd8, 32'hBBBB});

      // Load-use on lane 2, then load data merged in MEM.
      lane2(1, 5, 32'h123, 1); re1 = 1; raddr1 = 5; mem_ldata_i2 = 32'hDEADBEEF;
      #1;
      chk("lu_req", {63'd0, load_use_stall_req}, 64'd1);
      tick(); idle(); #1;
      chk("lu_mem2", {mem_we_o2, mem_waddr_o2, mem_wdata_o2}, {1'b1, 5'd5, 32'hDEADBEEF});
      chk("lu_clear", {63'd0, load_use_stall_req}, 64'd0);
      mem_ldata_i2 = 0;

      // Bubble: MEM empties while WB takes the old MEM content.
      lane1(1, 9, 32'h99, 0);
      tick(); stall = 4'b0111; lane1(1, 10, 32'hA0, 0);
      tick(); idle(); stall = 0; #1;
      chk("bub_mem", {63'd0, mem_we_o1}, 64'd0);
      chk("bub_wb",  {wb_we_o1, wb_waddr_o1, wb_wdata_o1}, {1'b1, 5'd9, 32'h99});

      // Hold for three cycles, then release.
      lane1(1, 11, 32'hB1, 0); tick();
      lane1(1, 12, 32'hC2, 0); tick();
      stall = 4'b1111; lane1(1, 13, 32'hD3, 0);
      for (int i = 0; i < 3; i++) begin
         #1;
         chk($sformatf("hold%0d_mem", i), {mem_we_o1, mem_waddr_o1, mem_wdata_o1}, {1'b1, 5'd12, 32'hC2});
         chk($sformatf("hold%0d_wb", i),  {wb_we_o1, wb_waddr_o1, wb_wdata_o1}, {1'b1, 5'd11, 32'hB1});
         tick();
      end
      stall = 0; idle(); #1;
      chk("hold_end_mem", {mem_we_o1, mem_waddr_o1, mem_wdata_o1}, {1'b1, 5'd12, 32'hC2});
      tick(); #1;
      chk("rel_wb",  {wb_we_o1, wb_waddr_o1, wb_wdata_o1}, {1'b1, 5'd12, 32'hC2});
      chk("rel_mem", {63'd0, mem_we_o1}, 64'd0);

      // Flush with a result in MEM and a load-use hazard in EX.
      lane1(1, 14, 32'hE1, 0); tick();
      flush = 1; stall = 4'b1111; lane1(1, 15, 32'hF1, 1); re1 = 1; raddr1 = 15; #1;
      chk("fl_ex_we", {63'd0, ex_we_o1}, 64'd0);
      chk("fl_lu",    {63'd0, load_use_stall_req}, 64'd0);
      chk("fl_mem_pre", {63'd0, mem_we_o1}, 64'd1);
      tick(); flush = 0; stall = 0; idle(); #1;
      chk("fl_mem", {63'd0, mem_we_o1}, 64'd0);
      chk("fl_wb",  {63'd0, wb_we_o1}, 64'd0);

      // Writes to register 0.
      lane1(1, 0, 32'h77, 0); #1;
      chk("r0_ex", {63'd0, ex_we_o1}, {63'd0, !R0_SQ});
      tick(); idle(); #1;
      chk("r0_mem", {63'd0, mem_we_o1}, {63'd0, !R0_SQ});
      tick(); #1;
      chk("r0_wb", {63'd0, wb_we_o1}, {63'd0, !R0_SQ});

      // Reset during a hold: pipeline restarts empty.
      lane1(1, 20, 32'h2020, 0); tick();
      lane1(1, 21, 32'h2121, 0); tick();
      stall = 4'b1111; rst = 0; tick();
      rst = 1; stall = 0; idle(); #1;
      chk("rst_hold_mem", {62'd0, mem_we_o1, mem_we_o2}, 64'd0);
      chk("rst_hold_wb",  {62'd0, wb_we_o1, wb_we_o2}, 64'd0);

      // Randomized run against the stage model; first cycle resets both.
      for (int n = 0; n < 2; n++) begin
         m_mem[n] = '{0, 0, 0, 0};
         m_wb[n]  = '{0, 0, 0, 0};
      end
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         rst   = (c == 0) ? 1'b0 : ($urandom_range(0, 49) != 0);
         flush = ($urandom_range(0, 15) == 0);
         stall = 4'($urandom);
         lane1($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), $urandom, $urandom_range(0, 2) == 0);
         lane2($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), $urandom, $urandom_range(0, 2) == 0);
         re1 = $urandom_range(0, 1); re2 = $urandom_range(0, 1);
         raddr1 = 5'($urandom_range(0, 7)); raddr2 = 5'($urandom_range(0, 7));
         mem_ldata_i1 = $urandom; mem_ldata_i2 = $urandom;
         #1;
         if (c > 0) begin
            model_outputs();
            chk("rnd_lu", {63'd0, load_use_stall_req}, {63'd0, exp_lu()});
            chk("rnd_ex_we", {62'd0, ex_we_o1, ex_we_o2},
                {62'd0, writes(ex_we_i1, ex_waddr_i1) && !flush, writes(ex_we_i2, ex_waddr_i2) && !flush});
            if (!ex_load_i1) chk("rnd_ex_d1", {ex_waddr_o1, ex_wdata_o1}, {ex_waddr_i1, ex_wdata_i1});
            chk_lane("rnd_mem1", mem_we_o1, mem_waddr_o1, mem_wdata_o1, e_mem[0]);
            chk_lane("rnd_mem2", mem_we_o2, mem_waddr_o2, mem_wdata_o2, e_mem[1]);
            chk_lane("rnd_wb1",  wb_we_o1, wb_waddr_o1, wb_wdata_o1, e_wb[0]);
            chk_lane("rnd_wb2",  wb_we_o2, wb_waddr_o2, wb_wdata_o2, e_wb[1]);
         end
         @(posedge clk);
         model_clock();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
